// File: rtl/cpu_exmem_stage.sv
// cpu_exmem_stage: execute -> memory pipeline register built as a 2-entry
// skid buffer (main entry drives out_*, skid entry absorbs one accept while
// the main entry is stalled). Branch outcome and illegal-op marker are
// resolved at accept and travel with the entry.
//
// Optional feature macro: CPU_EXMEM_STATUS_EN enables the sticky {C,Z,V,N}
// status register. Undefined: status_flags is 4'b0, flag_clear is ignored.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  upstream handshake (in_ready is registered)
//   in_result, in_op, in_rd, in_carry/zero/overflow/negative  entry + ALU flags
//   out_valid/out_ready downstream handshake
//   out_result, out_op, out_rd, out_branch_taken, out_illegal  presented entry
//   status_flags, flag_clear  sticky status register and its clear
module cpu_exmem_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  in_carry,
  input  logic                  in_zero,
  input  logic                  in_overflow,
  input  logic                  in_negative,
  input  logic [4:0]            in_op,
  input  logic [4:0]            in_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [4:0]            out_op,
  output logic [4:0]            out_rd,
  output logic                  out_branch_taken,
  output logic                  out_illegal,
  output logic [3:0]            status_flags,
  input  logic                  flag_clear
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic [4:0]            op;
    logic [4:0]            rd;
    logic                  taken;
    logic                  illegal;
  } entry_t;

  function automatic logic branch_dec(input logic [4:0] op, input logic z,
                                      input logic n, input logic v);
    logic lt;
    lt = n ^ v;
    case (op)
      5'b10010: branch_dec = 1'b1;        // JUMP
      5'b10011: branch_dec = z;           // BEQ
      5'b10100: branch_dec = ~z;          // BNE
      5'b10101: branch_dec = lt;          // BLT
      5'b10110: branch_dec = ~z & ~lt;    // BGT
      5'b10111: branch_dec = ~lt;         // BGE
      5'b11000: branch_dec = z | lt;      // BLE
      default:  branch_dec = 1'b0;
    endcase
  endfunction

  entry_t main_q, main_d, skid_q, skid_d, in_ent;
  logic   main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, rdy_q;
  logic   accept, retire;

  assign accept = in_valid & rdy_q;
  assign retire = main_vld_q & out_ready;

  always_comb begin
    in_ent.result  = in_result;
    in_ent.op      = in_op;
    in_ent.rd      = in_rd;
    in_ent.taken   = branch_dec(in_op, in_zero, in_negative, in_overflow);
    in_ent.illegal = (in_op >= 5'b11001);
  end

  // Main slot refills from skid first to keep FIFO order; in_ready is low
  // whenever skid is full, so accept and a skid->main move never coincide.
  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (!main_vld_q || retire) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = accept;
        if (accept) main_d = in_ent;
      end
    end else if (accept) begin
      skid_d     = in_ent;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= ~skid_vld_d;
    end
  end

  assign in_ready         = rdy_q;
  assign out_valid        = main_vld_q;
  assign out_result       = main_q.result;
  assign out_op           = main_q.op;
  assign out_rd           = main_q.rd;
  assign out_branch_taken = main_q.taken;
  assign out_illegal      = main_q.illegal;

`ifdef CPU_EXMEM_STATUS_EN
  logic [3:0] flags_q, flags_d;

  // ALU ops (00000-01111) load flags; a coinciding clear loses to the load.
  always_comb begin
    flags_d = flags_q;
    if (accept && !in_op[4])
      flags_d = {in_carry, in_zero, in_overflow, in_negative};
    else if (flag_clear)
      flags_d = 4'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) flags_q <= 4'b0;
    else     flags_q <= flags_d;
  end

  assign status_flags = flags_q;
`else
  logic unused_status;
  assign unused_status = ^{flag_clear, in_carry};
  assign status_flags  = 4'b0;
`endif

endmodule
